// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants and unpacked-operand types for the
// floating-point multiplier datapath.
package fp32_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned SIG_W   = FRAC_W + 1;
  localparam int unsigned PROD_W  = 2 * SIG_W;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    fp_class_t        cls;
  } fp_unpacked_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits one binary32 operand into sign, effective exponent, significand
// (with hidden bit) and class.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]  op,
  output fp_unpacked_t up
);

  // Subnormals use effective exponent 1 with a zero hidden bit.
  always_comb begin
    up.sign = op[31];
    up.exp  = op[30:23];
    up.sig  = {1'b1, op[22:0]};
    up.cls  = NORM;
    if (op[30:23] == 8'h00) begin
      up.exp = 8'd1;
      up.sig = {1'b0, op[22:0]};
      up.cls = (op[22:0] == 23'd0) ? ZERO : SUB;
    end else if (op[30:23] == 8'hFF) begin
      up.cls = (op[22:0] == 23'd0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp32_mul.sv
// Binary32 multiplier, round-to-nearest-even, combinational datapath into a
// single output register (latency 1, throughput 1).
module fp32_mul
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] IN1,
  input  logic [31:0] IN2,
  output logic [31:0] OUT,
  output logic        out_valid
);

  fp_unpacked_t a_up, b_up;

  logic [PROD_W-1:0] prod_c, norm_c, shr_c;
  logic [5:0]        lz_c;
  logic              found_c;
  logic signed [10:0] exp_c;
  logic [10:0]       shamt_c;
  logic [4:0]        sh_c;
  logic              uflow_c, oflow_c, lost_c, guard_c, rnd_c, sticky_c, inc_c;
  logic [7:0]        exp_base_c;
  logic [30:0]       mag_c;
  logic              sign_c;
  logic [31:0]       result_c;
  logic [31:0]       out_d, out_q;
  logic              out_valid_d, out_valid_q;

  fp32_unpack u_unpack_a (.op(IN1), .up(a_up));
  fp32_unpack u_unpack_b (.op(IN2), .up(b_up));

  // Leading-zero count of the raw significand product.
  always_comb begin
    lz_c    = '0;
    found_c = 1'b0;
    for (int i = PROD_W - 1; i >= 0; i--) begin
      if (!found_c && prod_c[i]) begin
        lz_c    = 6'(PROD_W - 1 - i);
        found_c = 1'b1;
      end
    end
  end

  // Multiply, normalize to bit 47, denormalize on underflow, round, select specials.
  always_comb begin
    sign_c  = a_up.sign ^ b_up.sign;
    prod_c  = PROD_W'(a_up.sig) * PROD_W'(b_up.sig);
    norm_c  = prod_c << lz_c;
    exp_c   = 11'(a_up.exp) + 11'(b_up.exp) - 11'(BIAS) + 11'd1 - 11'(lz_c);
    uflow_c = (exp_c < 11'sd1);
    oflow_c = (exp_c >= $signed(11'(EXP_MAX)));
    shamt_c = 11'(11'sd1 - exp_c);
    sh_c    = 5'd0;
    if (uflow_c) begin
      sh_c = (shamt_c >= 11'd26) ? 5'd26 : shamt_c[4:0];
    end
    shr_c    = norm_c >> sh_c;
    lost_c   = |(norm_c & ~({PROD_W{1'b1}} << sh_c));
    guard_c  = shr_c[23];
    rnd_c    = shr_c[22];
    sticky_c = (|shr_c[21:0]) | lost_c;
    inc_c    = guard_c & (rnd_c | sticky_c | shr_c[24]);
    // Hidden bit is added back through the significand, so the base is exp-1.
    exp_base_c = uflow_c ? 8'd0 : 8'(exp_c[7:0] - 8'd1);
    mag_c      = {exp_base_c, 23'd0} + 31'(shr_c[47:24]) + 31'(inc_c);

    result_c = {sign_c, mag_c};
    if (a_up.cls == NAN || b_up.cls == NAN) begin
      result_c = QNAN;
    end else if ((a_up.cls == INF && b_up.cls == ZERO) ||
                 (a_up.cls == ZERO && b_up.cls == INF)) begin
      result_c = QNAN;
    end else if (a_up.cls == INF || b_up.cls == INF) begin
      result_c = {sign_c, POS_INF[30:0]};
    end else if (a_up.cls == ZERO || b_up.cls == ZERO) begin
      result_c = {sign_c, 31'd0};
    end else if (oflow_c) begin
      result_c = {sign_c, POS_INF[30:0]};
    end
  end

  always_comb begin
    out_d       = in_valid ? result_c : out_q;
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp32_mul.sv
// Directed-vector bench for fp32_mul plus a handful of random normal pairs
// checked against a double-precision based RNE reference.
module tb_fp32_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] IN1, IN2;
  logic [31:0] OUT;
  logic        out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  fp32_mul dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .IN1      (IN1),
    .IN2      (IN2),
    .OUT      (OUT),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Widen a normal binary32 to binary64 bit pattern.
  function automatic logic [63:0] f2d(input logic [31:0] x);
    logic [10:0] e;
    e = 11'(x[30:23]) + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  // Exact double product of two floats, then RNE down to 24 significand bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] pb;
    logic [52:0] m;
    logic [10:0] e;
    logic        inc;
    logic [30:0] mag;
    p   = $bitstoreal(f2d(a)) * $bitstoreal(f2d(b));
    pb  = $realtobits(p);
    m   = {1'b1, pb[51:0]};
    e   = pb[62:52] - 11'd896;
    inc = m[28] & ((|m[27:0]) | m[29]);
    mag = {e[7:0], m[51:29]} + 31'(inc);
    return {pb[63], mag};
  endfunction

  // Drive one operation at posedge+1, check the registered result one edge later.
  task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    in_valid = 1'b1;
    IN1      = a;
    IN2      = b;
    @(posedge clk); #1;
    check({tag, "_out"}, OUT, exp);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"one_x_two",   32'h3F800000, 32'h40000000, 32'h40000000});
    vecs.push_back('{"two_x_one",   32'h40000000, 32'h3F800000, 32'h40000000});
    vecs.push_back('{"two_x_two",   32'h40000000, 32'h40000000, 32'h40800000});
    vecs.push_back('{"one_x_m1",    32'h3F800000, 32'hBF800000, 32'hBF800000});
    vecs.push_back('{"two_x_m1",    32'h40000000, 32'hBF800000, 32'hC0000000});
    vecs.push_back('{"inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000});
    vecs.push_back('{"nan_x_one",   32'h7FC00001, 32'h3F800000, 32'h7FC00000});
    vecs.push_back('{"ninf_x_two",  32'hFF800000, 32'h40000000, 32'hFF800000});
    vecs.push_back('{"nzero_x_two", 32'h80000000, 32'h40000000, 32'h80000000});
    vecs.push_back('{"nzero_x_inf", 32'h80000000, 32'h7F800000, 32'h7FC00000});
    vecs.push_back('{"max_x_two",   32'h7F7FFFFF, 32'h40000000, 32'h7F800000});
    vecs.push_back('{"minn_x_half", 32'h00800000, 32'h3F000000, 32'h00400000});
    vecs.push_back('{"mins_x_half", 32'h00000001, 32'h3F000000, 32'h00000000});
    vecs.push_back('{"mins_x_2p23", 32'h00000001, 32'h4B000000, 32'h00800000});
    vecs.push_back('{"mins_x_2p126",32'h00000001, 32'h7E800000, 32'h34000000});
    vecs.push_back('{"sub_carry",   32'h00FFFFFF, 32'h3F000000, 32'h00800000});
    vecs.push_back('{"ulp_sq",      32'h3F800001, 32'h3F800001, 32'h3F800002});
    vecs.push_back('{"m_sub_x_two", 32'h80400000, 32'h40000000, 32'h80800000});
  end

  initial begin
    logic [31:0] ra, rb, r;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    IN1      = 32'd0;
    IN2      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", OUT, 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) mul(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Idle cycle: result holds, valid drops.
    in_valid = 1'b0;
    IN1      = 32'h40000000;
    IN2      = 32'h40000000;
    @(posedge clk); #1;
    check("idle_hold", OUT, vecs[vecs.size()-1].exp);
    check("idle_vld",  32'(out_valid), 32'd0);

    for (int k = 0; k < 24; k++) begin
      r  = $urandom;
      ra = {r[31], 8'($urandom_range(154, 100)), r[22:0]};
      r  = $urandom;
      rb = {r[31], 8'($urandom_range(154, 100)), r[22:0]};
      mul($sformatf("rand%0d", k), ra, rb, ref_mul(ra, rb));
    end

    // Reset with in_valid held high, then resume.
    mul("pre_rst", 32'h40000000, 32'h40000000, 32'h40800000);
    rst_n = 1'b0;
    IN1   = 32'h3F800000;
    IN2   = 32'h40000000;
    @(posedge clk); #1;
    check("mid_rst_out", OUT, 32'd0);
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    mul("post_rst", 32'h40000000, 32'hBF800000, 32'hC0000000);
    mul("post_rst2", 32'h3F800000, 32'hBF800000, 32'hBF800000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
